// File: rtl/cmp_rr_scheduler.sv
// cmp_rr_scheduler: shares one W-bit keyed comparator between two requesters.
//   Round-robin arbitration, operand latching, result held until ack,
//   per-requester saturating hit counters.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req0/x0/y0/key0     requester 0 request + operands (key 0=diff, 1=equal)
//   req1/x1/y1/key1     requester 1 request + operands
//   gnt[1:0]            one-hot grant pulse, one cycle
//   done/done_id/r      result valid (held until ack), owner, compare result
//   ack                 consumer takes the result (only sampled while done=1)
//   hits0/hits1         saturating counts of r=1 results per requester
//   busy                any state other than IDLE

// Combinational keyed comparator: key=0 -> x!=y, key=1 -> x==y.
module cmp_unit #(
  parameter int W = 3
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         key,
  output logic         r
);
  logic diff, equal;
  assign diff  = |(x ^ y);
  assign equal = &(x ~^ y);
  assign r     = key ? equal : diff;
endmodule

// Saturating up-counter, one per requester.
module hit_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

module cmp_rr_scheduler #(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [W-1:0]     x0,
  input  logic [W-1:0]     y0,
  input  logic             key0,
  input  logic             req1,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     y1,
  input  logic             key1,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             done_id,
  output logic             r,
  input  logic             ack,
  output logic [CNT_W-1:0] hits0,
  output logic [CNT_W-1:0] hits1,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t state_q, state_d;

  logic         prio;
  logic [W-1:0] xl, yl;
  logic         keyl;
  logic         any_req, win, cmp_r, ack_fire;

  logic [1:0][CNT_W-1:0] hits;

  assign any_req  = req0 | req1;
  // req1 wins when it is alone, or when both ask and it holds priority
  assign win      = req1 & (~req0 | prio);
  assign ack_fire = (state_q == HOLD) & ack;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EVAL;
      EVAL:    state_d = HOLD;
      HOLD:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
  end

  cmp_unit #(.W(W)) u_cmp (.x(xl), .y(yl), .key(keyl), .r(cmp_r));

  // datapath registers; operands only move on an IDLE grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= 1'b0;
      r       <= 1'b0;
      prio    <= 1'b0;
      xl      <= '0;
      yl      <= '0;
      keyl    <= 1'b0;
    end else begin
      gnt <= '0;
      case (state_q)
        IDLE: if (any_req) begin
          gnt     <= win ? 2'b10 : 2'b01;
          done_id <= win;
          xl      <= win ? x1 : x0;
          yl      <= win ? y1 : y0;
          keyl    <= win ? key1 : key0;
        end
        EVAL: begin
          r    <= cmp_r;
          done <= 1'b1;
        end
        HOLD: if (ack) begin
          done <= 1'b0;
          prio <= ~done_id;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_hit
    hit_cnt #(.CNT_W(CNT_W)) u_hit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ack_fire & r & (done_id == i[0])),
      .cnt   (hits[i])
    );
  end

  assign hits0 = hits[0];
  assign hits1 = hits[1];
endmodule
